mmio_bus_bridge: RTL
====================

// Module: mmio_bus_bridge
// PURPOSE
//  Parametrised CPU-to-peripheral bridge that succeeds the single-cycle, fixed-map bridge.
//  Decodes one CPU data access to one of NSLV address windows.
//  Checks alignment, range, access width and writability, and raises AdEL/AdES.
//  Drives a req/ack handshake so slaves may take a variable number of cycles; the CPU stalls meanwhile.
//  Sits between the MEM stage and the DM/TC/GPIO/Tube/UART peripherals.
// PARAMETERS
//  NSLV        4                    number of slave windows (1..8)
//  SLV_BASE    {NSLV x 32b}         window base addresses, packed, slave 0 in LSBs
//  SLV_MASK    {NSLV x 32b}         hit iff (addr & MASK) == BASE
//  SLV_WORDONLY {NSLV x 1b}         1 = only lw/sw are legal in this window
//  SLV_RO      {NSLV x 1b}          1 = stores to this window are illegal
//  TIMEOUT_CYC 16                   ack wait limit; used only with BRIDGE_TIMEOUT_EN
// PORTS
//  clk        in   1        clock
//  rst        in   1        asynchronous reset, active-high
//  cpu_req    in   1        access valid this cycle
//  cpu_we     in   1        1 = store
//  cpu_sel    in   3        MEM_* width code from const.v
//  cpu_addr   in   32       byte address
//  cpu_wdata  in   32       unaligned store data, in the low bits
//  cpu_stall  out  1        hold MEM stage
//  cpu_exc    out  5        0 or EXCCODE_ADEL/ADES
//  cpu_rvalid out  1        one-cycle completion pulse
//  cpu_rdata  out  32       sign/zero-extended load data
//  slv_req    out  NSLV     one-hot request
//  slv_addr   out  32       shared address
//  slv_wdata  out  32       lane-shifted data
//  slv_be     out  4        byte enables; 0 for loads
//  slv_ack    in   NSLV     completion from each slave
//  slv_rdata  in   NSLV*32  read data, slave i at [32i+:32]
// BEHAVIOUR
//  Reset (async, active-high):
//   - State goes to IDLE.
//   - All outputs are 0: slv_req, slv_be, cpu_stall, cpu_rvalid, cpu_rdata, cpu_exc.
//   - A transaction in flight is abandoned with no response.
//  Decode (combinational):
//   - Hit = lowest-index matching window.
//   - cpu_exc is ADEL for a load and ADES for a store when any of these hold:
//     misaligned (word: addr[1:0]!=0; half: addr[0]); no hit; non-word access to a WORDONLY window; store to an RO window.
//   - cpu_exc is valid in the same cycle as cpu_req. No slave is touched and cpu_stall stays 0.
//  States:
//   - IDLE: cpu_req with no exc goes to BUSY.
//     The address, one-hot select, be, wdata, sel and addr[1:0] are registered.
//     cpu_stall is asserted combinationally in this cycle.
//   - BUSY:
//     slv_req[hit]=1; addr, wdata and be are held stable; cpu_stall=1.
//     The ack of the selected slave only is sampled. The first cycle it can be seen is the cycle after entering BUSY.
//     On ack: capture slv_rdata[hit], drop slv_req, go to RESP.
//   - RESP:
//     cpu_rvalid=1 and cpu_stall=0.
//     cpu_rdata is the captured word, extended per the registered sel and addr[1:0]. It is 0 for stores.
//     Next state is IDLE. A new cpu_req in RESP is not accepted; accepting starts again from IDLE.
//  Timing and other rules:
//   - Minimum latency: accept in cycle 0, ack in cycle 1, rvalid in cycle 2.
//   - Acks from unselected slaves, or acks arriving in IDLE/RESP, are ignored.
//   - cpu_req is ignored while cpu_stall=1.
//   - cpu_rdata holds its value until the next RESP.
// CONFIGURATION
//  `BRIDGE_TIMEOUT_EN defined:
//   - A counter clears on entering BUSY and increments each BUSY cycle.
//   - When it reaches TIMEOUT_CYC without an ack, the bridge drops slv_req and goes to RESP.
//   - In that RESP cycle, cpu_exc = ADEL/ADES (per the registered we) and cpu_rdata = 0.
//  `BRIDGE_TIMEOUT_EN undefined:
//   - No counter exists. BUSY waits for an ack indefinitely.
//   - cpu_exc is only ever a decode result.
// STRUCTURE
//  const.v: MEM_* width codes, EXCCODE_ADEL/ADES, state encodings (BR_IDLE/BUSY/RESP).
//  Sub-module bridge_lane (combinational):
//   - byte-enable and wdata shift from sel and addr[1:0];
//   - load extension of rdata.
//   - It is instantiated twice: once for the request, once for the response.
//  Decoder and FSM stay in the top module. Use a generate loop over NSLV.
// TESTING
//  1. sw 0x1234_5678 to 0x0000_0100 (DM); ack 3 cycles after req.
//     -> slv_req[0] for 3 cycles, be=4'hF, stall for 4 cycles, a single rvalid, exc=0.
//  2. lb from 0x0000_0103; slave returns 0x80FF_FF00.
//     -> cpu_rdata=0xFFFF_FF80. lbu on the same data -> 0x0000_0080.
//  3. lh at 0x0000_0101; sw to unmapped 0x0000_9000; sh to a WORDONLY window.
//     -> exc 4, then 5, then 5; no slv_req and no stall in any case.
//  4. A store to an RO window -> exc=5. A load from the same window -> completes normally.
//  5. Assert rst in the 2nd BUSY cycle.
//     -> slv_req drops at once, state is IDLE, no rvalid.
//     -> A following lw completes normally.
//  6. With BRIDGE_TIMEOUT_EN and TIMEOUT_CYC=16, the slave never acks.
//     -> slv_req held for 16 cycles, then rvalid with exc=ADEL and rdata=0.
//  Also: a stray ack from an unselected slave during BUSY -> ignored.

Source files
------------

// File: rtl/mmio_bus_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mmio_bus_bridge_pkg
// Purpose  : Shared constants and types for the MMIO bus bridge: access-width
//            codes, exception codes, FSM state encodings, request record.
// Revision : 1.0 - initial release
// ============================================================================
package mmio_bus_bridge_pkg;

  // Access width codes presented by the MEM stage on cpu_sel
  localparam logic [2:0] MEM_WORD  = 3'd0;
  localparam logic [2:0] MEM_HALF  = 3'd1;
  localparam logic [2:0] MEM_HALFU = 3'd2;
  localparam logic [2:0] MEM_BYTE  = 3'd3;
  localparam logic [2:0] MEM_BYTEU = 3'd4;

  // Address-error exception codes
  localparam logic [4:0] EXCCODE_ADEL = 5'd4;
  localparam logic [4:0] EXCCODE_ADES = 5'd5;

  // Bridge FSM state encodings
  localparam int          BR_STATE_W = 2;
  localparam logic [1:0]  BR_IDLE    = 2'd0;
  localparam logic [1:0]  BR_BUSY    = 2'd1;
  localparam logic [1:0]  BR_RESP    = 2'd2;

  // Request fields latched on accept and held for the whole transaction
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [2:0]  sel;
    logic [1:0]  off;
    logic        we;
  } br_req_t;

  // Misalignment check: words need off==0, halves need an even offset
  function automatic logic misaligned(input logic [2:0] sel, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if (sel == MEM_WORD)
      bad = (off != 2'b00);
    else if (sel == MEM_HALF || sel == MEM_HALFU)
      bad = off[0];
    return bad;
  endfunction

  // Width codes outside the defined set are treated as illegal accesses
  function automatic logic bad_width(input logic [2:0] sel);
    return (sel > MEM_BYTEU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_bus_bridge_lane.sv
`default_nettype none
// ============================================================================
// Module   : mmio_bus_bridge_lane
// Purpose  : Byte-lane steering. Produces byte enables and lane-shifted store
//            data from width/offset, and extends load data back to 32 bits.
//            Purely combinational; used once on the request side and once on
//            the response side of the bridge.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_bus_bridge_lane
  import mmio_bus_bridge_pkg::*;
(
  input  logic [2:0]  sel,
  input  logic [1:0]  off,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  output logic [3:0]  be,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_out
);

  logic [31:0] rd_shifted;

  // Byte enables and store-data placement on the addressed lanes
  always_comb begin
    be        = 4'b0000;
    wdata_out = wdata_in << {off, 3'b000};
    case (sel)
      MEM_WORD:             be = 4'b1111;
      MEM_HALF, MEM_HALFU:  be = off[1] ? 4'b1100 : 4'b0011;
      MEM_BYTE, MEM_BYTEU:  be = 4'b0001 << off;
      default:              be = 4'b0000;
    endcase
  end

  // Bring the addressed bytes down to bit 0 and sign/zero-extend
  always_comb begin
    rd_shifted = rdata_in >> {off, 3'b000};
    rdata_out  = rdata_in;
    case (sel)
      MEM_HALF:  rdata_out = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      MEM_HALFU: rdata_out = {16'h0000, rd_shifted[15:0]};
      MEM_BYTE:  rdata_out = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      MEM_BYTEU: rdata_out = {24'h000000, rd_shifted[7:0]};
      default:   rdata_out = rdata_in;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mmio_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : mmio_bus_bridge
// Purpose  : CPU-to-peripheral bridge. Decodes a data access onto one of NSLV
//            address windows, raises AdEL/AdES for illegal accesses, and runs
//            a req/ack handshake with the selected slave while stalling the CPU.
// Options  : define BRIDGE_TIMEOUT_EN to abort a transaction that receives no
//            ack within TIMEOUT_CYC busy cycles (reported as AdEL/AdES).
// Revision : 1.0 - initial release
// ============================================================================
module mmio_bus_bridge
  import mmio_bus_bridge_pkg::*;
#(
  parameter int                NSLV         = 4,
  parameter logic [NSLV*32-1:0] SLV_BASE    = {32'h0000_7F20, 32'h0000_7F10, 32'h0000_7F00, 32'h0000_0000},
  parameter logic [NSLV*32-1:0] SLV_MASK    = {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_C000},
  parameter logic [NSLV-1:0]   SLV_WORDONLY = 4'b0010,
  parameter logic [NSLV-1:0]   SLV_RO       = 4'b0100,
  parameter int                TIMEOUT_CYC  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [2:0]        cpu_sel,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_stall,
  output logic [4:0]        cpu_exc,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  output logic [NSLV-1:0]   slv_req,
  output logic [31:0]       slv_addr,
  output logic [31:0]       slv_wdata,
  output logic [3:0]        slv_be,
  input  logic [NSLV-1:0]   slv_ack,
  input  logic [NSLV*32-1:0] slv_rdata
);

  logic [BR_STATE_W-1:0] state;
  logic [BR_STATE_W-1:0] state_nxt;

  logic [NSLV-1:0] hit;
  logic [NSLV-1:0] hit_first;
  logic            dec_err;
  logic            accept;
  logic            ack_sel;
  logic            timeout;
  logic            timed_out;

  br_req_t         req_q;
  logic [NSLV-1:0] sel_oh;
  logic [31:0]     sel_rdata;
  logic [31:0]     rdata_q;

  logic [3:0]      req_be;
  logic [31:0]     req_wdata;
  logic [31:0]     rsp_rdata;

  // ---------------------------------------------------------------- decode
  for (genvar i = 0; i < NSLV; i++) begin : g_win
    assign hit[i] = (cpu_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32];
  end

  // Isolate the lowest set bit: lowest-index window wins on overlap
  assign hit_first = hit & (~hit + NSLV'(1));

  assign dec_err = misaligned(cpu_sel, cpu_addr[1:0])
                 | bad_width(cpu_sel)
                 | ~(|hit)
                 | ((|(hit_first & SLV_WORDONLY)) & (cpu_sel != MEM_WORD))
                 | (cpu_we & (|(hit_first & SLV_RO)));

  assign accept  = (state == BR_IDLE) && cpu_req && !dec_err;
  assign ack_sel = |(slv_ack & sel_oh);

  // Read-data mux driven by the registered one-hot select
  always_comb begin
    sel_rdata = 32'h0000_0000;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_oh[i])
        sel_rdata = sel_rdata | slv_rdata[32*i +: 32];
    end
  end

  // Request-side lane: enables and shifted data from the live CPU access
  mmio_bus_bridge_lane u_lane_req (
    .sel       (cpu_sel),
    .off       (cpu_addr[1:0]),
    .wdata_in  (cpu_wdata),
    .rdata_in  (32'h0000_0000),
    .be        (req_be),
    .wdata_out (req_wdata),
    .rdata_out ()
  );

  // Response-side lane: extension using the width/offset latched at accept
  mmio_bus_bridge_lane u_lane_rsp (
    .sel       (req_q.sel),
    .off       (req_q.off),
    .wdata_in  (32'h0000_0000),
    .rdata_in  (sel_rdata),
    .be        (),
    .wdata_out (),
    .rdata_out (rsp_rdata)
  );

  // ---------------------------------------------------------------- timeout
`ifdef BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] busy_cnt;

  // Busy-cycle counter, cleared on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      busy_cnt <= '0;
    else if (accept)
      busy_cnt <= '0;
    else if (state == BR_BUSY)
      busy_cnt <= busy_cnt + CNT_W'(1);
  end

  // The TIMEOUT_CYC-th busy cycle without an ack ends the wait
  assign timeout = (state == BR_BUSY) && !ack_sel && (busy_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Remember that the pending response is an abort
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      timed_out <= 1'b0;
    else if (accept)
      timed_out <= 1'b0;
    else if (timeout)
      timed_out <= 1'b1;
  end
`else
  assign timeout   = 1'b0;
  assign timed_out = 1'b0;
`endif

  // ---------------------------------------------------------------- FSM
  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= BR_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      BR_IDLE: if (accept) state_nxt = BR_BUSY;
      BR_BUSY: if (ack_sel || timeout) state_nxt = BR_RESP;
      BR_RESP: state_nxt = BR_IDLE;
      default: state_nxt = BR_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    slv_req    = '0;
    slv_be     = 4'b0000;
    cpu_stall  = 1'b0;
    cpu_rvalid = 1'b0;
    cpu_exc    = 5'd0;
    case (state)
      BR_IDLE: begin
        if (cpu_req && dec_err)
          cpu_exc = cpu_we ? EXCCODE_ADES : EXCCODE_ADEL;
        cpu_stall = accept;
      end
      BR_BUSY: begin
        slv_req   = sel_oh;
        slv_be    = req_q.be;
        cpu_stall = 1'b1;
      end
      BR_RESP: begin
        cpu_rvalid = 1'b1;
        if (timed_out)
          cpu_exc = req_q.we ? EXCCODE_ADES : EXCCODE_ADEL;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  // Latch the request on accept; the slave sees it unchanged throughout BUSY
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q  <= '0;
      sel_oh <= '0;
    end else if (accept) begin
      req_q.addr  <= cpu_addr;
      req_q.wdata <= req_wdata;
      req_q.be    <= cpu_we ? req_be : 4'b0000;
      req_q.sel   <= cpu_sel;
      req_q.off   <= cpu_addr[1:0];
      req_q.we    <= cpu_we;
      sel_oh      <= hit_first;
    end
  end

  // Capture the extended load word on completion; held until the next response
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rdata_q <= 32'h0000_0000;
    else if (state == BR_BUSY && ack_sel)
      rdata_q <= req_q.we ? 32'h0000_0000 : rsp_rdata;
    else if (timeout)
      rdata_q <= 32'h0000_0000;
  end

  assign cpu_rdata = rdata_q;
  assign slv_addr  = req_q.addr;
  assign slv_wdata = req_q.wdata;

endmodule
`default_nettype wire
